// File: rtl/ucie_ctl_pkg.sv
// ucie_ctl_pkg
//   Shared definitions for the UCIe control-path FSMs (TX and RX).
//   - rx_state_e     : RX FSM state encodings
//   - UCIE_ACTIVE_ENC: FDI state-status encoding for Active
package ucie_ctl_pkg;

  localparam logic [3:0] UCIE_ACTIVE_ENC = 4'b0001;

  typedef enum logic [1:0] {
    RESET    = 2'b00,
    RX_WAIT  = 2'b01,
    ACTIVE   = 2'b10,
    OVERFLOW = 2'b11
  } rx_state_e;

endpackage

// File: rtl/ucie_ctl_sat_cnt.sv
// ucie_ctl_sat_cnt
//   Saturating up-counter with synchronous active-high clear.
//   Ports:
//     clk - block clock
//     rst - synchronous active-high clear
//     inc - increment request (ignored once all ones)
//     cnt - current count, holds at 2**W-1
module ucie_ctl_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ucie_ctl_rx_fsm.sv
// ucie_ctl_rx_fsm
//   RX path controller between the RDI (physical layer) and FDI (protocol
//   layer) sides. Opens the RX path on request, steers RDI beats into a
//   first-word-fallthrough FIFO and drains it toward FDI, flagging a sticky
//   overflow when a beat arrives with the FIFO full.
//   Optional feature: define UCIE_RX_ERR_CNT_EN to add o_rx_overf_cnt, a
//   saturating count of ACTIVE->OVERFLOW transitions.
//   Ports:
//     clk, rst                - clock, synchronous active-high reset
//     i_fdi_pl_state_sts      - adapter state status
//     i_rdi_pl_rx_active_req  - PHY request to open the RX path
//     i_rdi_pl_valid          - RDI beat valid (no backpressure)
//     wfull, rempty           - RX FIFO flags
//     o_rdi_lp_rx_active_sts  - RX path open acknowledge
//     o_fdi_pl_valid          - data valid toward protocol layer
//     o_rx_overf_err          - receive overflow error
//     winc, wrst_n            - FIFO write increment / write reset (active-low)
//     rinc, rrst_n            - FIFO read increment / read reset (active-low)
//     o_rx_overf_cnt          - overflow event count (UCIE_RX_ERR_CNT_EN only)
//
//   state    | meaning
//   RESET    | adapter not Active; FIFO held in reset
//   RX_WAIT  | adapter Active, waiting for PHY RX request; FIFO held in reset
//   ACTIVE   | RX path open; beats written, FIFO drained to FDI
//   OVERFLOW | beat dropped on full FIFO; error sticky, writes blocked, reads drain
module ucie_ctl_rx_fsm
  import ucie_ctl_pkg::*;
#(
  parameter logic [3:0] UCIE_ACTIVE = UCIE_ACTIVE_ENC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_fdi_pl_state_sts,
  input  logic       i_rdi_pl_rx_active_req,
  input  logic       i_rdi_pl_valid,
  input  logic       wfull,
  input  logic       rempty,
  output logic       o_rdi_lp_rx_active_sts,
  output logic       o_fdi_pl_valid,
  output logic       o_rx_overf_err,
  output logic       winc,
  output logic       wrst_n,
  output logic       rinc,
  output logic       rrst_n
`ifdef UCIE_RX_ERR_CNT_EN
  ,
  output logic [7:0] o_rx_overf_cnt
`endif
);

  rx_state_e state_q;
  rx_state_e state_d;
  logic      sts_active;

  assign sts_active = (i_fdi_pl_state_sts == UCIE_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    o_rdi_lp_rx_active_sts = 1'b0;
    o_fdi_pl_valid         = 1'b0;
    o_rx_overf_err         = 1'b0;
    winc                   = 1'b0;
    wrst_n                 = 1'b0;
    rinc                   = 1'b0;
    rrst_n                 = 1'b0;

    case (state_q)
      RESET: begin
        if (sts_active) state_d = RX_WAIT;
      end

      RX_WAIT: begin
        if (!sts_active)                 state_d = RESET;
        else if (i_rdi_pl_rx_active_req) state_d = ACTIVE;
      end

      ACTIVE: begin
        o_rdi_lp_rx_active_sts = 1'b1;
        wrst_n                 = 1'b1;
        rrst_n                 = 1'b1;
        // FWFT FIFO and no FDI ready: every non-empty cycle is a pop.
        o_fdi_pl_valid         = ~rempty;
        rinc                   = ~rempty;
        winc                   = i_rdi_pl_valid & ~wfull;
        o_rx_overf_err         = i_rdi_pl_valid & wfull;
        if (!sts_active)                            state_d = RESET;
        else if (!i_rdi_pl_rx_active_req)           state_d = RX_WAIT;
        else if (i_rdi_pl_valid && wfull)           state_d = OVERFLOW;
      end

      OVERFLOW: begin
        o_rdi_lp_rx_active_sts = 1'b1;
        wrst_n                 = 1'b1;
        rrst_n                 = 1'b1;
        o_fdi_pl_valid         = ~rempty;
        rinc                   = ~rempty;
        o_rx_overf_err         = 1'b1;
        if (!sts_active)                  state_d = RESET;
        else if (!i_rdi_pl_rx_active_req) state_d = RX_WAIT;
      end

      default: state_d = RESET;
    endcase
  end

`ifdef UCIE_RX_ERR_CNT_EN
  logic ovf_enter;

  assign ovf_enter = (state_q == ACTIVE) && (state_d == OVERFLOW);

  ucie_ctl_sat_cnt #(
    .W (8)
  ) u_ovf_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ovf_enter),
    .cnt (o_rx_overf_cnt)
  );
`endif

endmodule

// File: doc/ucie_ctl_rx_fsm.md
UCIE_CTL_RX_FSM -- requirements
Module: ucie_ctl_rx_fsm

Interface
REQ-001 Parameter UCIE_ACTIVE, default 4'b0001: FDI state-status encoding for Active.
REQ-002 Port clk, input, 1: single block clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port i_fdi_pl_state_sts, input, 4: adapter state status.
REQ-005 Port i_rdi_pl_rx_active_req, input, 1: physical layer requests the RX path to open.
REQ-006 Port i_rdi_pl_valid, input, 1: RDI receive flit chunk valid; there is no backpressure path to it.
REQ-007 Ports wfull and rempty, input, 1 each: RX FIFO full and empty flags.
REQ-008 Port o_rdi_lp_rx_active_sts, output, 1: RX path open acknowledge.
REQ-009 Port o_fdi_pl_valid, output, 1: data valid toward the protocol layer.
REQ-010 Port o_rx_overf_err, output, 1: receive overflow error.
REQ-011 Ports winc, wrst_n, rinc and rrst_n, output, 1 each: RX FIFO write and read controls (FIFO resets active-low).

Function
REQ-012 The FSM SHALL have four states with these encodings: RESET 2'b00, RX_WAIT 2'b01, ACTIVE 2'b10, OVERFLOW 2'b11.
REQ-013 RESET SHALL go to RX_WAIT when sts==UCIE_ACTIVE; otherwise it stays in RESET.
REQ-014 From RX_WAIT:
- sts!=UCIE_ACTIVE: go to RESET.
- rx_active_req=1: go to ACTIVE.
- Otherwise: stay.
REQ-015 From ACTIVE, in priority order:
- sts!=UCIE_ACTIVE: go to RESET.
- rx_active_req=0: go to RX_WAIT.
- i_rdi_pl_valid & wfull: go to OVERFLOW.
- Otherwise: stay.
REQ-016 From OVERFLOW:
- sts!=UCIE_ACTIVE: go to RESET.
- rx_active_req=0: go to RX_WAIT.
- Otherwise: stay (the error is sticky).
REQ-017 Illegal or unknown state SHALL go to RESET.
REQ-018 wrst_n and rrst_n SHALL be 0 in RESET and RX_WAIT, and 1 in ACTIVE and OVERFLOW.
REQ-019 o_rdi_lp_rx_active_sts SHALL be 1 exactly in ACTIVE and OVERFLOW, i.e. one cycle after req is sampled high in RX_WAIT.
REQ-020 In ACTIVE, winc SHALL equal i_rdi_pl_valid & ~wfull, combinationally in the same cycle.
REQ-021 In ACTIVE with i_rdi_pl_valid & wfull:
- o_rx_overf_err=1 in that same cycle.
- winc=0.
- The beat is dropped.
REQ-022 In OVERFLOW:
- o_rx_overf_err=1.
- winc=0 regardless of valid.
- The read side keeps draining.
REQ-023 In ACTIVE and OVERFLOW, o_fdi_pl_valid SHALL equal ~rempty, and rinc SHALL equal o_fdi_pl_valid. The FIFO is first-word-fallthrough and FDI RX has no ready.
REQ-024 In ACTIVE with simultaneous write and read, winc and rinc SHALL both assert in the same cycle.
REQ-025 In RESET and RX_WAIT, all outputs except the counter SHALL be 0; valid arriving in these states SHALL be dropped without an error.
REQ-026 The transition out of ACTIVE or OVERFLOW SHALL take effect at the next edge; the FIFO resets assert in the following cycle.

Reset
REQ-027 With rst=1 at a clk edge, the state SHALL become RESET; this overrides every transition.
REQ-028 While in RESET, all outputs SHALL be 0, including wrst_n and rrst_n.
REQ-029 Reset mid-operation (ACTIVE or OVERFLOW) SHALL abandon FIFO contents with no error indication.

Configuration
REQ-030 With UCIE_RX_ERR_CNT_EN defined, output o_rx_overf_cnt [7:0] SHALL exist.
- It increments by 1 on each ACTIVE->OVERFLOW transition.
- It saturates at 255 and never wraps.
- It is cleared only by rst and holds through RESET and RX_WAIT.
REQ-031 Without UCIE_RX_ERR_CNT_EN, the port and the counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 State encodings and the UCIE_ACTIVE encoding SHALL live in the shared package ucie_ctl_pkg, which the TX and RX FSMs both import.
REQ-033 The saturating counter SHALL be sub-module ucie_ctl_sat_cnt (width parameter, default 8), instantiated only under UCIE_RX_ERR_CNT_EN.

Verification
REQ-034 Scenario: rst=1 for 2 cycles, then sts=0001 with req=0. Required: state RX_WAIT, wrst_n=rrst_n=0, rx_active_sts=0.
REQ-035 Scenario: req=1 in RX_WAIT, then valid=1 for 4 cycles with wfull=0 and rempty toggling. Required: rx_active_sts=1 one cycle later; winc=1 on each of the 4 cycles; rinc=fdi_pl_valid=~rempty.
REQ-036 Scenario: in ACTIVE, wfull=1 and valid=1. Required: o_rx_overf_err=1 and winc=0 that cycle; state OVERFLOW next; with rempty=0, rinc=1 continues. Counter reads 1 with the macro defined.
REQ-037 Scenario: in OVERFLOW, req drops. Required: RX_WAIT next cycle, err=0, FIFO resets asserted. Re-entering ACTIVE and overflowing again gives counter=2.
REQ-038 Scenario: 300 forced overflow cycles with the macro defined. Required: counter saturates at 255.
REQ-039 Scenario: sts changes from 0001 to 0011 while in ACTIVE. Required: RESET next cycle, all outputs 0. Additionally, rst asserted in OVERFLOW returns all outputs to 0 next cycle.
